// File: rtl/audio_delay_pkg.sv
// Shared sizing defaults and FSM encoding for the audio delay-buffer controller.
package audio_delay_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DELAY_0_DEF = 4096;
  localparam int DELAY_1_DEF = 16384;
  localparam int DELAY_2_DEF = 32768;
  localparam int DELAY_3_DEF = 65535;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RETUNE = 2'd3
  } state_e;

endpackage

// File: rtl/sel_change_detect.sv
// Two-flop synchroniser for the delay-select switches plus a compare against the
// code currently in use; latency 2 cycles to sel_sync, change is combinational on it.
module sel_change_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel_async,
  input  logic [1:0] sel_latched,
  output logic [1:0] sel_sync,
  output logic       change
);

  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = sel_async;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'd0;
      sync2_q <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sel_sync = sync2_q;
  assign change   = (sync2_q != sel_latched);

endmodule

// File: rtl/delay_buffer_ctrl.sv
// Address/strobe controller for an external dual-port delay buffer: writes each
// sample, reads it back a selectable number of samples later, mutes until full.
module delay_buffer_ctrl
  import audio_delay_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DELAY_0 = DELAY_0_DEF,
  parameter int DELAY_1 = DELAY_1_DEF,
  parameter int DELAY_2 = DELAY_2_DEF,
  parameter int DELAY_3 = DELAY_3_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_strobe,
  input  logic [1:0]        delay_sel,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_enable,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_valid,
  output logic [1:0]        state,
  output logic [ADDR_W-1:0] fill_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic [ADDR_W-1:0] fill_count_q, fill_count_d;
  logic [ADDR_W-1:0] active_delay_q, active_delay_d;
  logic [1:0]        active_sel_q, active_sel_d;
  logic              write_enable_q, write_enable_d;

  logic [1:0]        sel_sync;
  logic              sel_change;
  logic              accept;

  function automatic logic [ADDR_W-1:0] delay_of(input logic [1:0] sel);
    case (sel)
      2'd0:    delay_of = ADDR_W'(DELAY_0);
      2'd1:    delay_of = ADDR_W'(DELAY_1);
      2'd2:    delay_of = ADDR_W'(DELAY_2);
      default: delay_of = ADDR_W'(DELAY_3);
    endcase
  endfunction

  sel_change_detect u_sel_change_detect (
    .clk         (clk),
    .reset       (reset),
    .sel_async   (delay_sel),
    .sel_latched (active_sel_q),
    .sel_sync    (sel_sync),
    .change      (sel_change)
  );

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    write_address_d = write_address_q;
    fill_count_d    = fill_count_q;
    active_delay_d  = active_delay_q;
    active_sel_d    = active_sel_q;
    write_enable_d  = 1'b0;
    read_address_d  = wr_ptr_q - active_delay_q;

    accept = enable && sample_strobe && ((state_q == ST_FILL) || (state_q == ST_RUN));

    if (accept) begin
      write_enable_d  = 1'b1;
      write_address_d = wr_ptr_q;
    end

    // The pointer advances during the pulse itself, so a pulse that straddles
    // a transition to IDLE or RETUNE still consumes its slot.
    if (write_enable_q) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_FILL;
          fill_count_d = '0;
        end
      end
      ST_FILL, ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (sel_change) begin
          state_d      = ST_RETUNE;
          fill_count_d = '0;
        end else begin
          if (accept && (fill_count_q < active_delay_q)) begin
            fill_count_d = fill_count_q + 1'b1;
          end
          if ((state_q == ST_FILL) && (fill_count_q == active_delay_q)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RETUNE: begin
        active_sel_d   = sel_sync;
        active_delay_d = delay_of(sel_sync);
        // A strobe taken on the cycle the change was seen is pulsing now; count it.
        fill_count_d   = ADDR_W'(write_enable_q);
        state_d        = enable ? ST_FILL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      write_address_q <= '0;
      read_address_q  <= '0;
      fill_count_q    <= '0;
      active_delay_q  <= ADDR_W'(DELAY_0);
      active_sel_q    <= 2'd0;
      write_enable_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      write_address_q <= write_address_d;
      read_address_q  <= read_address_d;
      fill_count_q    <= fill_count_d;
      active_delay_q  <= active_delay_d;
      active_sel_q    <= active_sel_d;
      write_enable_q  <= write_enable_d;
    end
  end

  // Masking with reset kills a pulse that is already on the wire when reset arrives.
  assign write_enable  = write_enable_q & ~reset;
  assign write_address = write_address_q;
  assign read_address  = read_address_q;
  assign read_valid    = (state_q == ST_RUN);
  assign state         = state_q;
  assign fill_count    = fill_count_q;

endmodule

// File: tb/tb_delay_buffer_ctrl.sv
// Directed bench for delay_buffer_ctrl, scaled to an 8-bit address space so
// fills and pointer wrap complete in a few thousand cycles.
module tb_delay_buffer_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sample_strobe;
  logic [1:0]    delay_sel;
  logic [AW-1:0] write_address;
  logic          write_enable;
  logic [AW-1:0] read_address;
  logic          read_valid;
  logic [1:0]    state;
  logic [AW-1:0] fill_count;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_ptr;

  delay_buffer_ctrl #(
    .ADDR_W  (AW),
    .DELAY_0 (16),
    .DELAY_1 (40),
    .DELAY_2 (64),
    .DELAY_3 (255)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .sample_strobe (sample_strobe),
    .delay_sel     (delay_sel),
    .write_address (write_address),
    .write_enable  (write_enable),
    .read_address  (read_address),
    .read_valid    (read_valid),
    .state         (state),
    .fill_count    (fill_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues n strobes three cycles apart, checking each write pulse address.
  task automatic strobe_n(input int n);
    for (int i = 0; i < n; i++) begin
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      checks++;
      if (write_enable !== 1'b1 || write_address !== exp_ptr) begin
        errors++;
        $display("FAIL strobe_pulse: we=%0b addr=%0d, expected we=1 addr=%0d", write_enable, write_address, exp_ptr);
      end
      tick();
      tick();
      exp_ptr = exp_ptr + 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sample_strobe = 1'b0; delay_sel = 2'd0;
    tick();
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (write_address !== 8'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", write_address); end
    checks++; if (read_address !== 8'd0) begin errors++; $display("FAIL reset_raddr: got %0d expected 0", read_address); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", write_enable); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b expected 0", read_valid); end
    checks++; if (fill_count !== 8'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_count); end
    reset = 1'b0;
    tick();
    checks++; if (read_address !== 8'd240) begin errors++; $display("FAIL idle_raddr_delay0: got %0d expected 240", read_address); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state); end
  endtask

  task automatic test_fill_run();
    enable = 1'b1;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL enter_fill: got %0d expected 1", state); end
    checks++; if (fill_count !== 8'd0) begin errors++; $display("FAIL fill_start: got %0d expected 0", fill_count); end
    exp_ptr = 8'd0;
    strobe_n(15);
    checks++; if (state !== 2'd1 || read_valid !== 1'b0) begin errors++; $display("FAIL fill_15: state=%0d rv=%0b expected 1/0", state, read_valid); end
    checks++; if (fill_count !== 8'd15) begin errors++; $display("FAIL fill_count_15: got %0d expected 15", fill_count); end
    strobe_n(1);
    checks++; if (state !== 2'd2 || read_valid !== 1'b1) begin errors++; $display("FAIL run_entry: state=%0d rv=%0b expected 2/1", state, read_valid); end
    checks++; if (fill_count !== 8'd16) begin errors++; $display("FAIL fill_full: got %0d expected 16", fill_count); end
    checks++; if (read_address !== 8'd0) begin errors++; $display("FAIL run_raddr: got %0d expected 0", read_address); end
  endtask

  task automatic test_run_hold();
    strobe_n(1);
    checks++; if (fill_count !== 8'd16) begin errors++; $display("FAIL run_fill_sat: got %0d expected 16", fill_count); end
    checks++; if (read_address !== 8'd1) begin errors++; $display("FAIL run_raddr_step: got %0d expected 1", read_address); end
  endtask

  task automatic test_retune();
    delay_sel = 2'd2;
    tick();
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL retune_early: got %0d expected 2", state); end
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL retune_state: got %0d expected 3", state); end
    checks++; if (read_valid !== 1'b0 || fill_count !== 8'd0) begin errors++; $display("FAIL retune_clear: rv=%0b fill=%0d expected 0/0", read_valid, fill_count); end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL retune_to_fill: got %0d expected 1", state); end
    tick();
    checks++; if (read_address !== 8'd209) begin errors++; $display("FAIL retune_raddr: got %0d expected 209", read_address); end
    strobe_n(63);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL refill_63: got %0d expected 1", state); end
    strobe_n(1);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL refill_run: got %0d expected 2", state); end
    checks++; if (read_address !== 8'd17) begin errors++; $display("FAIL refill_raddr: got %0d expected 17", read_address); end
  endtask

  task automatic test_retune_strobe();
    delay_sel = 2'd1;
    tick();
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rs_pre: got %0d expected 2", state); end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL rs_retune: got %0d expected 3", state); end
    checks++; if (write_enable !== 1'b1 || write_address !== 8'd81) begin errors++; $display("FAIL rs_pulse: we=%0b addr=%0d expected 1/81", write_enable, write_address); end
    tick();
    checks++; if (state !== 2'd1 || fill_count !== 8'd1) begin errors++; $display("FAIL rs_fill: state=%0d fill=%0d expected 1/1", state, fill_count); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rs_one_pulse: got %0b expected 0", write_enable); end
    tick();
    checks++; if (read_address !== 8'd42) begin errors++; $display("FAIL rs_raddr: got %0d expected 42", read_address); end
    exp_ptr = 8'd82;
  endtask

  task automatic test_enable_drop();
    strobe_n(9);
    checks++; if (fill_count !== 8'd10) begin errors++; $display("FAIL ed_fill10: got %0d expected 10", fill_count); end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    enable = 1'b0;
    checks++; if (write_enable !== 1'b1 || write_address !== 8'd91) begin errors++; $display("FAIL ed_pulse: we=%0b addr=%0d expected 1/91", write_enable, write_address); end
    tick();
    checks++; if (state !== 2'd0 || read_valid !== 1'b0) begin errors++; $display("FAIL ed_idle: state=%0d rv=%0b expected 0/0", state, read_valid); end
    tick();
    checks++; if (read_address !== 8'd52) begin errors++; $display("FAIL ed_ptr_held: got %0d expected 52", read_address); end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL ed_idle_ignore: got %0b expected 0", write_enable); end
    tick();
    enable = 1'b1;
    tick();
    checks++; if (state !== 2'd1 || fill_count !== 8'd0) begin errors++; $display("FAIL ed_restart: state=%0d fill=%0d expected 1/0", state, fill_count); end
    exp_ptr = 8'd92;
    strobe_n(1);
    checks++; if (fill_count !== 8'd1) begin errors++; $display("FAIL ed_refill: got %0d expected 1", fill_count); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_raddr;
    delay_sel = 2'd3;
    tick();
    tick();
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL wrap_retune: got %0d expected 3", state); end
    tick();
    checks++; if (state !== 2'd1 || fill_count !== 8'd0) begin errors++; $display("FAIL wrap_fill: state=%0d fill=%0d expected 1/0", state, fill_count); end
    strobe_n(254);
    checks++; if (state !== 2'd1 || fill_count !== 8'd254) begin errors++; $display("FAIL wrap_254: state=%0d fill=%0d expected 1/254", state, fill_count); end
    strobe_n(1);
    checks++; if (state !== 2'd2 || fill_count !== 8'd255) begin errors++; $display("FAIL wrap_run: state=%0d fill=%0d expected 2/255", state, fill_count); end
    checks++; if (read_address !== 8'd93) begin errors++; $display("FAIL wrap_raddr: got %0d expected 93", read_address); end
    for (int k = 0; k < 4; k++) begin
      strobe_n(1);
      exp_raddr = exp_ptr - 8'd255;
      checks++;
      if (read_address !== exp_raddr) begin
        errors++;
        $display("FAIL wrap_raddr_cont: got %0d expected %0d", read_address, exp_raddr);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rmw_pulse: got %0b expected 1", write_enable); end
    reset = 1'b1;
    #1;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rmw_cancel: got %0b expected 0", write_enable); end
    tick();
    checks++; if (state !== 2'd0 || read_valid !== 1'b0 || write_enable !== 1'b0) begin errors++; $display("FAIL rmw_ctrl: state=%0d rv=%0b we=%0b expected 0/0/0", state, read_valid, write_enable); end
    checks++; if (write_address !== 8'd0 || read_address !== 8'd0 || fill_count !== 8'd0) begin errors++; $display("FAIL rmw_regs: wa=%0d ra=%0d fill=%0d expected 0/0/0", write_address, read_address, fill_count); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_run();
    test_run_hold();
    test_retune();
    test_retune_strobe();
    test_enable_drop();
    test_wrap();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
